// File: rtl/mem_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_stall_ctrl
// Purpose  : Sequences a multi-cycle data-memory access for the instruction
//            sitting in the MEM stage. While the access is in flight, the
//            front of the pipeline (PC/IFID/IDEX/EXMEM) is frozen and bubbles
//            are fed into MEM/WB. In the release cycle (DONE) the load data is
//            presented to MEM/WB and the instruction advances.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT        cycles allowed in REQ+WAIT without mem_ack_i (1..255)
//   CNT_W          timeout counter width, 2**CNT_W > TIMEOUT
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-low reset
//   mem_read_i     MEM-stage instruction is a load
//   mem_write_i    MEM-stage instruction is a store
//   addr_i         MEM-stage effective address
//   wdata_i        MEM-stage store data
//   mem_ack_i      data memory: access complete this cycle
//   mem_rdata_i    data memory read data, valid with mem_ack_i
//   mem_req_o      data memory request (registered)
//   mem_we_o       1 = write, 0 = read; valid while mem_req_o = 1
//   mem_addr_o     latched access address
//   mem_wdata_o    latched store data
//   rdata_o        captured load data towards MEM/WB
//   stall_o        freeze PC, IFID, IDEX, EXMEM
//   memwb_bubble_o force MEM/WB write-back controls to zero this cycle
//   timeout_err_o  sticky flag: an access was abandoned on timeout
// ============================================================================
module mem_stall_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        memwb_bubble_o,
    output logic        timeout_err_o
);

    // ------------------------------------------------------------------------
    // State encoding and constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam logic [CNT_W-1:0] c_CNT_LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_terr;

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic [1:0] w_state_nxt;
    logic       w_acc;
    logic       w_stall;
    logic       w_launch;    // IDLE detected an access: latch and request
    logic       w_ack_take;  // acknowledge accepted in REQ/WAIT
    logic       w_timeout;   // no acknowledge and the cycle budget is spent
    logic       w_count;     // still waiting: advance the timeout counter

    assign w_acc = mem_read_i | mem_write_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and control decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_launch    = 1'b0;
        w_ack_take  = 1'b0;
        w_timeout   = 1'b0;
        w_count     = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                // The stall must be raised in the detection cycle itself,
                // otherwise EXMEM would advance past the access.
                if (w_acc) begin
                    w_stall     = 1'b1;
                    w_launch    = 1'b1;
                    w_state_nxt = c_ST_REQ;
                end
            end

            c_ST_REQ, c_ST_WAIT: begin
                w_stall = 1'b1;
                // An acknowledge in the last allowed cycle still wins over
                // the timeout.
                if (mem_ack_i) begin
                    w_ack_take  = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else if (r_cnt == c_CNT_LIMIT) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_DONE;
                end else begin
                    w_count     = 1'b1;
                    w_state_nxt = c_ST_WAIT;
                end
            end

            c_ST_DONE: begin
                // Release cycle: the instruction moves into MEM/WB, so it is
                // never requested a second time.
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Access datapath: latched request, timeout counter, load data, error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_terr  <= 1'b0;
        end else begin
            if (w_launch) begin
                // Inputs are only sampled here; later changes on the
                // MEM-stage bus are irrelevant. A store wins when both
                // read and write are flagged.
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_we    <= mem_write_i;
                r_req   <= 1'b1;
                r_cnt   <= c_CNT_ONE;
            end else if (w_ack_take) begin
                r_req <= 1'b0;
                if (!r_we) begin
                    r_rdata <= mem_rdata_i;
                end
            end else if (w_timeout) begin
                r_req  <= 1'b0;
                r_terr <= 1'b1;
                // An abandoned load hands zero to the pipeline rather than
                // stale data from an earlier access.
                if (!r_we) begin
                    r_rdata <= '0;
                end
            end else if (w_count) begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign mem_req_o      = r_req;
    assign mem_we_o       = r_we;
    assign mem_addr_o     = r_addr;
    assign mem_wdata_o    = r_wdata;
    assign rdata_o        = r_rdata;
    assign timeout_err_o  = r_terr;

    // While reset is held the state is IDLE, but a pending MEM-stage access
    // would otherwise raise the stall; reset must release the pipeline.
    assign stall_o        = w_stall & rst_i;
    assign memwb_bubble_o = w_stall & rst_i;

endmodule
`default_nettype wire

// File: doc/mem_stall_ctrl.md
Name: mem_stall_ctrl

Overview:
- Sequences multi-cycle data-memory accesses for the instruction currently in the MEM stage of the 5-stage pipeline.
- Drives the external data memory request/acknowledge handshake.
- Freezes PC/IFID/IDEX/EXMEM through stall_o and feeds bubbles into the MEM/WB pipeline register until the access completes.
- Supplies read data to MEM/WB in the release cycle.
- Sits between the EXMEM register outputs, the data memory and the MEMWB register inputs.

Parameters:
TIMEOUT, 255, maximum cycles spent in REQ+WAIT without mem_ack_i before the access is abandoned (1..255)
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-low reset
mem_read_i  input  1  MEM-stage instruction is a load (EXMEM M control)
mem_write_i  input  1  MEM-stage instruction is a store
addr_i  input  32  MEM-stage effective address (EXMEM ALU result)
wdata_i  input  32  MEM-stage store data
mem_ack_i  input  1  data memory: access complete this cycle
mem_rdata_i  input  32  data memory read data, valid when mem_ack_i=1
mem_req_o  output  1  data memory request, registered
mem_we_o  output  1  1=write, 0=read, valid while mem_req_o=1
mem_addr_o  output  32  latched access address
mem_wdata_o  output  32  latched store data
rdata_o  output  32  captured load data to MEMWB data_i
stall_o  output  1  freeze PC, IFID, IDEX, EXMEM
memwb_bubble_o  output  1  force MEMWB WB_i to 2'b00 this cycle
timeout_err_o  output  1  sticky: an access timed out

Behaviour:
- Reset (rst_i=0, asynchronous, also mid-access):
  - state=IDLE, timeout counter=0.
  - mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o and timeout_err_o all clear to 0.
  - stall_o=0, memwb_bubble_o=0.
  - An in-flight memory access is abandoned; no retry after reset.
- Define acc = mem_read_i | mem_write_i.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - acc=0: stay in IDLE, no stall.
  - acc=1:
    - stall_o=1 and memwb_bubble_o=1 combinationally in this same cycle.
    - At the clock edge: latch addr_i and wdata_i; mem_we_o<=mem_write_i (a write takes priority if both read and write are set); mem_req_o<=1; counter<=1; go to REQ.
- REQ and WAIT:
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable.
  - stall_o=1, memwb_bubble_o=1.
  - mem_ack_i=1: rdata_o<=mem_rdata_i on a read (rdata_o unchanged on a write); mem_req_o<=0; go to DONE.
  - Zero-wait acknowledge in REQ is legal.
  - No ack and counter==TIMEOUT: timeout_err_o<=1; mem_req_o<=0; rdata_o<=0 on a read; go to DONE.
  - Otherwise: counter increments; REQ goes to WAIT, WAIT stays in WAIT.
- DONE:
  - stall_o=0, memwb_bubble_o=0; the MEM instruction advances into MEMWB with rdata_o.
  - Go to IDLE unconditionally. The same instruction is never re-requested.
- Stall output: stall_o = (IDLE & acc) | REQ | WAIT. memwb_bubble_o is identical to stall_o.
- Latency:
  - Minimum stall is 2 cycles (IDLE-detect, REQ with ack).
  - Total stall is 2 + N cycles for an ack arriving N cycles after REQ.
  - Back-to-back memory instructions: IDLE re-detects the next instruction the cycle after DONE; the gap between consecutive accesses is exactly 1 non-stalled cycle (DONE).
- mem_ack_i in IDLE or DONE is spurious and ignored: no state change and no rdata_o update.
- timeout_err_o clears only on reset.
- Inputs are sampled at the IDLE-to-REQ edge only; later changes on addr_i/wdata_i are ignored.

Test Plan:
- Load with ack 3 cycles after REQ:
  - Stimulus: addr_i=0x00000010, mem_rdata_i=0x12345678.
  - Required: stall_o high for 5 cycles; mem_req_o high for 4 cycles with mem_we_o=0 and mem_addr_o=0x10; rdata_o=0x12345678 in DONE; memwb_bubble_o=0 in DONE.
- Zero-wait store:
  - Stimulus: mem_write_i=1, wdata_i=0xCAFEF00D, ack during REQ.
  - Required: stall_o high exactly 2 cycles; mem_we_o=1; mem_wdata_o=0xCAFEF00D; rdata_o unchanged.
- Back-to-back load then store, each acked in REQ:
  - Required: stall pattern 1,1,0,1,1,0; two separate requests; the second request uses the second address.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack ever.
  - Required: mem_req_o drops after 4 cycles; timeout_err_o=1 and stays 1; rdata_o=0; pipeline released in DONE.
- Reset mid-WAIT:
  - Stimulus: rst_i=0 pulse asynchronous to the clock.
  - Required: mem_req_o, stall_o and timeout_err_o are 0 immediately; state returns to IDLE; a later load proceeds normally.
- Spurious ack:
  - Stimulus: mem_ack_i=1 with mem_rdata_i=0xFFFFFFFF while IDLE with acc=0.
  - Required: no stall; rdata_o unchanged; mem_req_o stays 0.
